// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory bus arbiter.
package mem_arb_pkg;

   // Default machine word width (address and data)
   localparam int WORD_W_DEFAULT = 16;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // Which requester currently owns the bus
   typedef enum logic {
      OWN_P = 1'b0,
      OWN_S = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation guard for the memory bus arbiter: counts consecutive primary
// grants made while the secondary is waiting and raises force_s once the
// count reaches LIMIT, so the next arbitration goes to the secondary.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic idle,
   input  logic p_grant,
   input  logic s_grant,
   input  logic s_req,
   output logic force_s
);

   localparam logic [3:0] LIMIT_CNT = 4'(LIMIT);

   logic [3:0] cnt_reg;

   // Saturating count of primary wins over a waiting secondary
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (s_grant) begin
         cnt_reg <= '0;
      end else if (idle && !s_req) begin
         cnt_reg <= '0;
      end else if (p_grant && s_req && (cnt_reg != LIMIT_CNT)) begin
         cnt_reg <= cnt_reg + 4'd1;
      end
   end

   assign force_s = (cnt_reg == LIMIT_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the single main-memory port. Grants one requester at a
// time (primary preferred) and walks each access through ISSUE, the read
// latency wait and a one-cycle DONE. All outputs are registered.
// Optional: define MEM_ARB_STARVE_GUARD_EN to force a secondary grant after
// STARVE_LIMIT consecutive primary wins over a waiting secondary.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORD_W       = WORD_W_DEFAULT,
   parameter int READ_LAT     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [WORD_W-1:0] p_addr,
   input  logic [WORD_W-1:0] p_wdata,
   input  logic              s_req,
   input  logic              s_we,
   input  logic [WORD_W-1:0] s_addr,
   input  logic [WORD_W-1:0] s_wdata,
   output logic              p_gnt,
   output logic              s_gnt,
   output logic              p_done,
   output logic              s_done,
   output logic [WORD_W-1:0] p_rdata,
   output logic [WORD_W-1:0] s_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              busy
);

   // Reject out-of-range configurations at elaboration
   generate
      if ((READ_LAT < 1) || (READ_LAT > 7) || (STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_param
         $error("mem_bus_arbiter: READ_LAT must be 1..7 and STARVE_LIMIT 1..15");
      end
   endgenerate

   localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

   arb_state_t state_reg;
   owner_t     owner_reg;
   logic [2:0] wait_cnt_reg;

   logic any_req;
   logic pick_s;
   logic force_s;

   // Arbitration: primary wins unless the starvation guard forces the secondary
   always_comb begin
      any_req = p_req | s_req;
      pick_s  = s_req & (~p_req | force_s);
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic in_idle;
   logic p_grant_ev;
   logic s_grant_ev;

   assign in_idle    = (state_reg == IDLE);
   assign p_grant_ev = in_idle & any_req & ~pick_s;
   assign s_grant_ev = in_idle & pick_s;

   arb_starve_ctr #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk     (clk),
      .reset   (reset),
      .idle    (in_idle),
      .p_grant (p_grant_ev),
      .s_grant (s_grant_ev),
      .s_req   (s_req),
      .force_s (force_s)
   );
`else
   assign force_s = 1'b0;
`endif

   // Sequencer: the mem_* registers double as the latched request fields,
   // since they are only needed while in ISSUE and must be zero elsewhere
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         owner_reg    <= OWN_P;
         wait_cnt_reg <= '0;
         p_gnt        <= 1'b0;
         s_gnt        <= 1'b0;
         p_done       <= 1'b0;
         s_done       <= 1'b0;
         p_rdata      <= '0;
         s_rdata      <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         busy         <= 1'b0;
      end else begin
         p_done <= 1'b0;
         s_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  state_reg <= ISSUE;
                  busy      <= 1'b1;
                  mem_en    <= 1'b1;
                  if (pick_s) begin
                     owner_reg <= OWN_S;
                     s_gnt     <= 1'b1;
                     mem_we    <= s_we;
                     mem_addr  <= s_addr;
                     mem_wdata <= s_wdata;
                  end else begin
                     owner_reg <= OWN_P;
                     p_gnt     <= 1'b1;
                     mem_we    <= p_we;
                     mem_addr  <= p_addr;
                     mem_wdata <= p_wdata;
                  end
               end
            end
            ISSUE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               if (mem_we) begin
                  state_reg <= DONE;
                  if (owner_reg == OWN_S) s_done <= 1'b1;
                  else                    p_done <= 1'b1;
               end else begin
                  state_reg    <= WAIT;
                  wait_cnt_reg <= WAIT_INIT;
               end
            end
            WAIT: begin
               if (wait_cnt_reg == 3'd0) begin
                  state_reg <= DONE;
                  if (owner_reg == OWN_S) begin
                     s_rdata <= mem_rdata;
                     s_done  <= 1'b1;
                  end else begin
                     p_rdata <= mem_rdata;
                     p_done  <= 1'b1;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 3'd1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               p_gnt     <= 1'b0;
               s_gnt     <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (READ_LAT=2, STARVE_LIMIT=2).
// A small read-only memory model returns fixed data READ_LAT cycles after a
// read strobe and 16'hDEAD at every other time.
module tb_mem_bus_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         p_req = 1'b0, p_we = 1'b0;
   logic [W-1:0] p_addr = '0, p_wdata = '0;
   logic         s_req = 1'b0, s_we = 1'b0;
   logic [W-1:0] s_addr = '0, s_wdata = '0;
   logic         p_gnt, s_gnt, p_done, s_done;
   logic [W-1:0] p_rdata, s_rdata;
   logic         mem_en, mem_we;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
   logic         busy;

   int   n_checks = 0;
   int   n_errors = 0;
   logic excl_en = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .WORD_W       (W),
      .READ_LAT     (2),
      .STARVE_LIMIT (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .p_req     (p_req),
      .p_we      (p_we),
      .p_addr    (p_addr),
      .p_wdata   (p_wdata),
      .s_req     (s_req),
      .s_we      (s_we),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .p_gnt     (p_gnt),
      .s_gnt     (s_gnt),
      .p_done    (p_done),
      .s_done    (s_done),
      .p_rdata   (p_rdata),
      .s_rdata   (s_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Fixed read contents
   function automatic logic [W-1:0] rom(input logic [W-1:0] a);
      case (a)
         16'h0010: rom = 16'h1234;
         16'h0020: rom = 16'hCAFE;
         default:  rom = 16'h0BAD;
      endcase
   endfunction

   // Two-stage read pipeline: data valid READ_LAT=2 cycles after mem_en
   logic [W-1:0] rd0 = 16'hDEAD;
   logic [W-1:0] rd1 = 16'hDEAD;
   always @(posedge clk) begin
      rd0 <= (mem_en && !mem_we) ? rom(mem_addr) : 16'hDEAD;
      rd1 <= rd0;
   end
   assign mem_rdata = rd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Both grants must never be high together while enabled
   always @(negedge clk) begin
      if (excl_en) check("gnt_excl", 32'(p_gnt & s_gnt), 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [5:0] EXP_ORDER = 6'b100100; // bit i = 1 -> grant i to S
`else
   localparam logic [5:0] EXP_ORDER = 6'b000000;
`endif

   initial begin
      logic [5:0] owners;
      int         got_n;
      int         pulses;
      owners = '0;

      // Reset state
      ticks(2);
      check("rst_busy",   32'(busy),     32'd0);
      check("rst_gnt",    32'({p_gnt, s_gnt}), 32'd0);
      check("rst_done",   32'({p_done, s_done}), 32'd0);
      check("rst_mem_en", 32'({mem_en, mem_we}), 32'd0);
      check("rst_maddr",  32'(mem_addr), 32'd0);
      check("rst_mwdata", 32'(mem_wdata), 32'd0);
      check("rst_rdata",  {p_rdata, s_rdata}, 32'd0);
      reset = 1'b0;
      tick();

      // Primary read 0x0020, request withdrawn and address changed in ISSUE
      p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0020;
      tick();
      check("pr_mem_en", 32'(mem_en), 32'd1);
      check("pr_mem_we", 32'(mem_we), 32'd0);
      check("pr_maddr",  32'(mem_addr), 32'h0020);
      check("pr_gnt",    32'({p_gnt, s_gnt}), 32'd2);
      p_req = 1'b0; p_addr = 16'h0010;
      tick();
      check("pr_c2_en",   32'(mem_en), 32'd0);
      check("pr_c2_addr", 32'(mem_addr), 32'd0);
      check("pr_c2_busy", 32'(busy), 32'd1);
      tick();
      check("pr_c3_done", 32'(p_done), 32'd0);
      tick();
      check("pr_done",  32'(p_done), 32'd1);
      check("pr_rdata", 32'(p_rdata), 32'hCAFE);
      tick();
      check("pr_idle",  32'({busy, p_gnt, p_done}), 32'd0);
      $display("txn primary read  addr=0020 rdata=%h", p_rdata);

      // Primary write 0x4000 <= 0xBEEF
      p_req = 1'b1; p_we = 1'b1; p_addr = 16'h4000; p_wdata = 16'hBEEF;
      tick();
      check("pw_en_we", 32'({mem_en, mem_we}), 32'd3);
      check("pw_maddr", 32'(mem_addr), 32'h4000);
      check("pw_mwdat", 32'(mem_wdata), 32'hBEEF);
      p_req = 1'b0;
      tick();
      check("pw_done", 32'(p_done), 32'd1);
      tick();
      check("pw_busy",  32'(busy), 32'd0);
      check("pw_rdata", 32'(p_rdata), 32'hCAFE);
      $display("txn primary write addr=4000 wdata=BEEF");

      // Secondary read 0x0010
      s_req = 1'b1; s_we = 1'b0; s_addr = 16'h0010;
      tick();
      check("sr_gnt",   32'({p_gnt, s_gnt}), 32'd1);
      check("sr_maddr", 32'(mem_addr), 32'h0010);
      s_req = 1'b0;
      ticks(2);
      check("sr_c3_done", 32'(s_done), 32'd0);
      tick();
      check("sr_done",  32'({p_done, s_done}), 32'd1);
      check("sr_rdata", 32'(s_rdata), 32'h1234);
      tick();
      check("sr_idle",  32'(busy), 32'd0);
      $display("txn secondary read addr=0010 rdata=%h", s_rdata);

      // Simultaneous single write requests
      excl_en = 1'b1;
      p_req = 1'b1; p_we = 1'b1; p_addr = 16'h0100; p_wdata = 16'h1111;
      s_req = 1'b1; s_we = 1'b1; s_addr = 16'h0200; s_wdata = 16'h2222;
      tick();
      check("sim_c1_gnt",  32'({p_gnt, s_gnt}), 32'd2);
      check("sim_c1_addr", 32'(mem_addr), 32'h0100);
      p_req = 1'b0;
      tick();
      check("sim_c2_done", 32'({p_done, s_gnt}), 32'd2);
      tick();
      check("sim_c3_gap",  32'({busy, p_gnt, s_gnt}), 32'd0);
      tick();
      check("sim_c4_gnt",  32'({p_gnt, s_gnt}), 32'd1);
      check("sim_c4_data", {mem_addr, mem_wdata}, 32'h0200_2222);
      s_req = 1'b0;
      tick();
      check("sim_c5_done", 32'(s_done), 32'd1);
      tick();
      check("sim_c6_idle", 32'(busy), 32'd0);
      $display("txn simultaneous writes P then S");

      // Starvation: both requests held, writes
      p_req = 1'b1; p_we = 1'b1; s_req = 1'b1; s_we = 1'b1;
      got_n = 0;
      for (int c = 0; c < 40 && got_n < 6; c++) begin
         tick();
         if (mem_en) begin
            owners[got_n] = s_gnt;
            got_n++;
         end
      end
      p_req = 1'b0; s_req = 1'b0;
      check("stv_count", 32'(got_n), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("stv_grant%0d", i), 32'(owners[i]), 32'(EXP_ORDER[i]));
      end
      ticks(3);
      excl_en = 1'b0;
      $display("txn starvation grant order (bit=S) %b", owners);

      // Reset during WAIT of a primary read
      p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0010;
      tick();
      p_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rmid_busy",  32'({busy, p_gnt, s_gnt}), 32'd0);
      check("rmid_mem",   32'({mem_en, mem_we}), 32'd0);
      check("rmid_done",  32'({p_done, s_done}), 32'd0);
      check("rmid_rdata", {p_rdata, s_rdata}, 32'd0);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (p_done || s_done) pulses++;
      end
      check("rmid_no_done", 32'(pulses), 32'd0);
      p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0020;
      tick();
      check("rmid_new_en", 32'(mem_en), 32'd1);
      p_req = 1'b0;
      ticks(3);
      check("rmid_new_done",  32'(p_done), 32'd1);
      check("rmid_new_rdata", 32'(p_rdata), 32'hCAFE);
      tick();
      $display("txn reset mid-read then primary read rdata=%h", p_rdata);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
